// File: rtl/sorter_pkg.sv
// Shared definitions for the top-K sorters: FSM and slot-mode encodings and the
// signed rank compare, which is also reused by the parallel sorter benches.
package sorter_pkg;

   localparam int FRAC_BITS  = 6;
   localparam int DEF_DATA_W = 16;

   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_DRAIN = 1'b1
   } sorter_state_t;

   typedef enum logic [1:0] {
      SLOT_HOLD     = 2'd0,
      SLOT_INSERT   = 2'd1,
      SLOT_SHIFT_UP = 2'd2
   } slot_mode_t;

   // Strict compare, so equal values never displace each other (stable ordering).
   function automatic logic better(input logic signed [63:0] a,
                                   input logic signed [63:0] b,
                                   input logic               sortdir);
      return sortdir ? (a > b) : (a < b);
   endfunction

endpackage

// File: rtl/topk_slot.sv
// One bank entry of the top-K selector: holds a sample, its arrival index and a
// valid bit, and flags whether the incoming sample outranks what it holds.
module topk_slot
   import sorter_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int IDX_W   = 16,
   parameter int SORTDIR = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] new_data,
   input  logic [IDX_W-1:0]  new_idx,
   input  logic              upper_better,
   input  logic              upper_valid,
   input  logic [DATA_W-1:0] upper_data,
   input  logic [IDX_W-1:0]  upper_idx,
   input  logic              lower_valid,
   input  logic [DATA_W-1:0] lower_data,
   input  logic [IDX_W-1:0]  lower_idx,
   output logic              new_better,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [IDX_W-1:0]  idx
);

   // An empty slot always loses to the incoming sample.
   assign new_better = !valid ||
                       better(64'($signed(new_data)), 64'($signed(data)), SORTDIR != 0);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         idx   <= '0;
      end else begin
         case (mode)
            SLOT_INSERT: begin
               if (upper_better) begin
                  valid <= upper_valid;
                  data  <= upper_data;
                  idx   <= upper_idx;
               end else if (new_better) begin
                  valid <= 1'b1;
                  data  <= new_data;
                  idx   <= new_idx;
               end
            end
            SLOT_SHIFT_UP: begin
               valid <= lower_valid;
               data  <= lower_data;
               idx   <= lower_idx;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/streaming_topk_selector.sv
// Streaming top-K selector: keeps a sorted bank of the K best samples of a frame
// and drains it in rank order once the frame's last sample has been taken.
module streaming_topk_selector
   import sorter_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int K_LOG2  = 4,
   parameter int IDX_W   = 16,
   parameter int SORTDIR = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_idx,
   output logic              out_last,
   output logic              out_ovf
);

   localparam int K     = 1 << K_LOG2;
   localparam int CNT_W = K_LOG2 + 1;
   localparam logic [CNT_W-1:0] K_CNT   = CNT_W'(K);
   localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};

   sorter_state_t     state;
   slot_mode_t        slot_mode;
   logic [IDX_W-1:0]  idx_cnt;
   logic              idx_sat;
   logic [CNT_W-1:0]  fill_cnt;
   logic [CNT_W-1:0]  beat_cnt;
   logic [CNT_W-1:0]  emit_cnt;
   logic              accept;
   logic              out_hs;

   logic              s_valid  [K];
   logic [DATA_W-1:0] s_data   [K];
   logic [IDX_W-1:0]  s_idx    [K];
   logic              s_better [K];
   logic              up_better[K];
   logic              up_valid [K];
   logic [DATA_W-1:0] up_data  [K];
   logic [IDX_W-1:0]  up_idx   [K];
   logic              lo_valid [K];
   logic [DATA_W-1:0] lo_data  [K];
   logic [IDX_W-1:0]  lo_idx   [K];

   assign accept   = in_valid & in_ready;
   assign out_hs   = out_valid & out_ready;
   assign out_data = s_data[0];
   assign out_idx  = s_idx[0];

   always_comb begin
      slot_mode = SLOT_HOLD;
      if (state == ST_FILL && accept)
         slot_mode = SLOT_INSERT;
      else if (state == ST_DRAIN && out_hs)
         slot_mode = SLOT_SHIFT_UP;
   end

   for (genvar i = 0; i < K; i++) begin : g_slot
      if (i == 0) begin : g_head
         assign up_better[i] = 1'b0;
         assign up_valid[i]  = 1'b0;
         assign up_data[i]   = '0;
         assign up_idx[i]    = '0;
      end else begin : g_body
         assign up_better[i] = s_better[i-1];
         assign up_valid[i]  = s_valid[i-1];
         assign up_data[i]   = s_data[i-1];
         assign up_idx[i]    = s_idx[i-1];
      end
      if (i == K-1) begin : g_tail
         assign lo_valid[i] = 1'b0;
         assign lo_data[i]  = '0;
         assign lo_idx[i]   = '0;
      end else begin : g_next
         assign lo_valid[i] = s_valid[i+1];
         assign lo_data[i]  = s_data[i+1];
         assign lo_idx[i]   = s_idx[i+1];
      end

      topk_slot #(
         .DATA_W  (DATA_W),
         .IDX_W   (IDX_W),
         .SORTDIR (SORTDIR)
      ) u_slot (
         .clk          (clk),
         .rst          (rst),
         .mode         (slot_mode),
         .new_data     (in_data),
         .new_idx      (idx_cnt),
         .upper_better (up_better[i]),
         .upper_valid  (up_valid[i]),
         .upper_data   (up_data[i]),
         .upper_idx    (up_idx[i]),
         .lower_valid  (lo_valid[i]),
         .lower_data   (lo_data[i]),
         .lower_idx    (lo_idx[i]),
         .new_better   (s_better[i]),
         .valid        (s_valid[i]),
         .data         (s_data[i]),
         .idx          (s_idx[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_FILL;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_ovf   <= 1'b0;
         idx_cnt   <= '0;
         idx_sat   <= 1'b0;
         fill_cnt  <= '0;
         beat_cnt  <= '0;
         emit_cnt  <= '0;
      end else begin
         case (state)
            ST_FILL: begin
               in_ready <= 1'b1;
               if (accept) begin
                  // idx_sat marks that index IDX_MAX is taken; any later sample overflows.
                  if (idx_cnt == IDX_MAX) idx_sat <= 1'b1;
                  else                    idx_cnt <= idx_cnt + 1'b1;
                  if (idx_sat) out_ovf <= 1'b1;
                  if (fill_cnt != K_CNT) fill_cnt <= fill_cnt + 1'b1;
                  if (in_last) begin
                     state     <= ST_DRAIN;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     beat_cnt  <= (fill_cnt == K_CNT) ? K_CNT : fill_cnt + 1'b1;
                     out_last  <= (fill_cnt == '0);
                     emit_cnt  <= '0;
                  end
               end
            end
            ST_DRAIN: begin
               if (out_hs) begin
                  emit_cnt <= emit_cnt + 1'b1;
                  out_last <= (emit_cnt + CNT_W'(2)) == beat_cnt;
                  if (out_last) begin
                     state     <= ST_FILL;
                     in_ready  <= 1'b1;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_ovf   <= 1'b0;
                     idx_cnt   <= '0;
                     idx_sat   <= 1'b0;
                     fill_cnt  <= '0;
                     emit_cnt  <= '0;
                  end
               end
            end
            default: state <= ST_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_streaming_topk_selector.sv
// Bench for streaming_topk_selector: a max-keeping instance (K=4, IDX_W=4) and a
// min-keeping instance (K=4, IDX_W=16) checked against a sort-based frame model.
`timescale 1ns/1ps
module tb_streaming_topk_selector;

   localparam int NU    = 2;
   localparam int K     = 4;
   localparam int IDXW0 = 4;
   localparam int IDXW1 = 16;
   localparam int QD    = 64;

   logic clk_tb = 1'b0;
   always #5 clk_tb = ~clk_tb;

   logic        rst;
   logic        in_valid  [NU];
   logic        in_ready  [NU];
   logic [15:0] in_data   [NU];
   logic        in_last   [NU];
   logic        out_valid [NU];
   logic        out_ready [NU];
   logic [15:0] out_data  [NU];
   logic [15:0] out_idx   [NU];
   logic        out_last  [NU];
   logic        out_ovf   [NU];
   logic [IDXW0-1:0] out_idx_a;

   streaming_topk_selector #(.DATA_W(16), .K_LOG2(2), .IDX_W(IDXW0), .SORTDIR(1)) u_dut_max (
      .clk(clk_tb), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
      .out_idx(out_idx_a), .out_last(out_last[0]), .out_ovf(out_ovf[0])
   );
   assign out_idx[0] = {12'd0, out_idx_a};

   streaming_topk_selector #(.DATA_W(16), .K_LOG2(2), .IDX_W(IDXW1), .SORTDIR(0)) u_dut_min (
      .clk(clk_tb), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
      .out_idx(out_idx[1]), .out_last(out_last[1]), .out_ovf(out_ovf[1])
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit rst_q = 1'b1;
   int acc_cyc;
   int last_hs_cyc [NU];

   int frame_buf [NU][2048];
   int frame_len [NU];
   int exp_d [NU][QD];
   int exp_i [NU][QD];
   bit exp_l [NU][QD];
   bit exp_o [NU][QD];
   int exp_wr [NU];
   int exp_rd [NU];
   int got_d [NU][QD];
   int got_i [NU][QD];
   bit got_l [NU][QD];
   bit got_o [NU][QD];
   int got_n [NU];

   task automatic chk(input int u, input string name, input longint act, input longint want);
      n_cmp++;
      if (act != want) begin
         n_bad++;
         $display("FAIL u%0d %s: got %0d, expected %0d (cycle %0d)", u, name, act, want, cyc);
      end
   endtask

   task automatic timeout_fail(input int u, input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL u%0d %s: timed out (cycle %0d)", u, name, cyc);
   endtask

   // Frame model: stable rank sort of the whole frame, keep the first min(L,K).
   task automatic build_expected(input int u);
      bit used [2048];
      int len, n, best, idx_max;
      bit dir, ovf;
      len     = frame_len[u];
      idx_max = (u == 0) ? (1 << IDXW0) - 1 : (1 << IDXW1) - 1;
      dir     = (u == 0);
      ovf     = len > idx_max + 1;
      n       = (len < K) ? len : K;
      for (int j = 0; j < 2048; j++) used[j] = 1'b0;
      for (int r = 0; r < n; r++) begin
         best = -1;
         for (int j = 0; j < len; j++)
            if (!used[j] && (best < 0 ||
                (dir ? frame_buf[u][j] > frame_buf[u][best] : frame_buf[u][j] < frame_buf[u][best])))
               best = j;
         used[best] = 1'b1;
         exp_d[u][exp_wr[u] % QD] = frame_buf[u][best];
         exp_i[u][exp_wr[u] % QD] = (best > idx_max) ? idx_max : best;
         exp_l[u][exp_wr[u] % QD] = (r == n - 1);
         exp_o[u][exp_wr[u] % QD] = ovf;
         exp_wr[u]++;
      end
      frame_len[u] = 0;
   endtask

   task automatic send(input int u, input int d, input bit last);
      int n;
      bit rdy;
      in_valid[u] = 1'b1;
      in_data[u]  = 16'(d);
      in_last[u]  = last;
      n = 0;
      do begin
         @(negedge clk_tb);
         rdy = in_ready[u];
         @(posedge clk_tb);
         #1;
         n++;
      end while (!rdy && n < 200);
      in_valid[u] = 1'b0;
      in_last[u]  = 1'b0;
      if (!rdy) timeout_fail(u, "accept");
      else begin
         acc_cyc = cyc;
         frame_buf[u][frame_len[u]] = d;
         frame_len[u]++;
         if (last) build_expected(u);
      end
   endtask

   task automatic wait_drain(input int u);
      int n;
      n = 0;
      while (exp_rd[u] != exp_wr[u] && n < 500) begin
         @(posedge clk_tb);
         #1;
         n++;
      end
      if (exp_rd[u] != exp_wr[u]) timeout_fail(u, "drain");
   endtask

   task automatic chk_beat(input int u, input int b, input int d, input int i, input bit l, input bit o);
      chk(u, $sformatf("beat%0d_data", b), got_d[u][b], d);
      chk(u, $sformatf("beat%0d_idx", b), got_i[u][b], i);
      chk(u, $sformatf("beat%0d_last", b), got_l[u][b], l);
      chk(u, $sformatf("beat%0d_ovf", b), got_o[u][b], o);
   endtask

   always @(posedge clk_tb) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   // Per-cycle compare against the model's pending result beats.
   always @(negedge clk_tb) begin
      for (int u = 0; u < NU; u++) begin
         bit pend;
         int h;
         pend = exp_rd[u] != exp_wr[u];
         h    = exp_rd[u] % QD;
         chk(u, "in_ready", in_ready[u], !rst_q && !pend);
         chk(u, "out_valid", out_valid[u], pend);
         if (pend && out_valid[u]) begin
            chk(u, "out_data", int'($signed(out_data[u])), exp_d[u][h]);
            chk(u, "out_idx", out_idx[u], exp_i[u][h]);
            chk(u, "out_last", out_last[u], exp_l[u][h]);
            chk(u, "out_ovf", out_ovf[u], exp_o[u][h]);
            if (out_ready[u] && !rst) begin
               got_d[u][got_n[u] % QD] = int'($signed(out_data[u]));
               got_i[u][got_n[u] % QD] = int'(out_idx[u]);
               got_l[u][got_n[u] % QD] = out_last[u];
               got_o[u][got_n[u] % QD] = out_ovf[u];
               got_n[u]++;
               if (out_last[u]) last_hs_cyc[u] = cyc + 1;
               exp_rd[u]++;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int u = 0; u < NU; u++) begin
         in_valid[u] = 1'b0; in_data[u] = '0; in_last[u] = 1'b0; out_ready[u] = 1'b1;
         frame_len[u] = 0; exp_wr[u] = 0; exp_rd[u] = 0; got_n[u] = 0; last_hs_cyc[u] = 0;
      end

      @(negedge clk_tb);
      for (int u = 0; u < NU; u++) begin
         chk(u, "rst_out_data", out_data[u], 0);
         chk(u, "rst_out_idx", out_idx[u], 0);
         chk(u, "rst_out_last", out_last[u], 0);
         chk(u, "rst_out_ovf", out_ovf[u], 0);
      end
      @(posedge clk_tb); #1;
      rst = 1'b0;
      @(posedge clk_tb); #1;

      // Frame with a tie: equal values keep arrival order.
      got_n[0] = 0;
      send(0, 5, 0); send(0, -3, 0); send(0, 12, 0);
      send(0, 7, 0); send(0, 0, 0); send(0, 12, 1);
      wait_drain(0);
      chk(0, "f1_beats", got_n[0], 4);
      chk_beat(0, 0, 12, 2, 0, 0);
      chk_beat(0, 1, 12, 5, 0, 0);
      chk_beat(0, 2, 7, 3, 0, 0);
      chk_beat(0, 3, 5, 0, 1, 0);

      // Short frame: L < K emits exactly L beats.
      got_n[0] = 0;
      send(0, 100, 0); send(0, -100, 1);
      wait_drain(0);
      chk(0, "f2_beats", got_n[0], 2);
      chk_beat(0, 0, 100, 0, 0, 0);
      chk_beat(0, 1, -100, 1, 1, 0);

      // Keep-smallest instance, long descending frame.
      got_n[1] = 0;
      for (int i = 1023; i >= 0; i--) send(1, i, i == 0);
      wait_drain(1);
      chk(1, "f3_beats", got_n[1], 4);
      for (int b = 0; b < 4; b++) chk_beat(1, b, b, 1023 - b, b == 3, 0);

      // Stalled drain, then a new frame queued behind it.
      got_n[0] = 0;
      send(0, 3, 0); send(0, 1, 0); send(0, 4, 0); send(0, 1, 1);
      fork
         begin
            for (int c = 0; c < 15; c++) begin
               out_ready[0] = (c % 3 == 0);
               @(posedge clk_tb); #1;
            end
            out_ready[0] = 1'b1;
         end
         begin
            send(0, -7, 0);
            chk(0, "new_frame_gap", acc_cyc - last_hs_cyc[0], 1);
            send(0, 2, 1);
         end
      join
      wait_drain(0);
      chk(0, "f4_beats", got_n[0], 6);
      chk_beat(0, 0, 4, 2, 0, 0);
      chk_beat(0, 1, 3, 0, 0, 0);
      chk_beat(0, 2, 1, 1, 0, 0);
      chk_beat(0, 3, 1, 3, 1, 0);
      chk_beat(0, 4, 2, 1, 0, 0);
      chk_beat(0, 5, -7, 0, 1, 0);

      // Index overflow on a 4-bit index, then a clean frame.
      got_n[0] = 0;
      for (int i = 0; i < 20; i++) send(0, i, i == 19);
      wait_drain(0);
      send(0, 5, 0); send(0, 6, 0); send(0, 7, 1);
      wait_drain(0);
      chk(0, "f5_beats", got_n[0], 7);
      for (int b = 0; b < 4; b++) chk_beat(0, b, 19 - b, 15, b == 3, 1);
      chk_beat(0, 4, 7, 2, 0, 0);
      chk_beat(0, 5, 6, 1, 0, 0);
      chk_beat(0, 6, 5, 0, 1, 0);

      // Reset in the middle of a drain discards the rest of it.
      got_n[0] = 0;
      send(0, 10, 0); send(0, 20, 0); send(0, 30, 0); send(0, 40, 1);
      @(posedge clk_tb); #1;
      @(posedge clk_tb); #1;
      rst = 1'b1;
      @(posedge clk_tb); #1;
      rst = 1'b0;
      for (int u = 0; u < NU; u++) begin
         exp_rd[u] = exp_wr[u];
         frame_len[u] = 0;
      end
      @(negedge clk_tb);
      chk(0, "mid_rst_beats", got_n[0], 2);
      chk(0, "mid_rst_data", out_data[0], 0);
      chk(0, "mid_rst_idx", out_idx[0], 0);
      chk(0, "mid_rst_last", out_last[0], 0);
      chk_beat(0, 0, 40, 3, 0, 0);
      chk_beat(0, 1, 30, 2, 0, 0);
      send(0, 9, 1);
      wait_drain(0);
      chk(0, "f6_beats", got_n[0], 3);
      chk_beat(0, 2, 9, 0, 1, 0);

      repeat (3) @(posedge clk_tb);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/streaming_topk_selector.md
# streaming_topk_selector

Streaming top-K selector, the serial successor to the fully parallel 2^N→2^M partial sorter. Accepts a frame of signed Q-format samples one per cycle over a valid/ready handshake and keeps a sorted bank of the K best samples with their arrival indices. Frame length is arbitrary and need not be a power of two. On frame end it drains the bank in rank order over a second handshake. Sits between the sample producer and downstream peak/candidate logic when the input set is too large or too variable for the parallel sorter.

## Interface
- DATA_W, 16, sample width, signed two's complement (Q9.6 in the default system)
- K_LOG2, 4, bank depth K = 2^K_LOG2, range 1..6
- IDX_W, 16, arrival-index width
- SORTDIR, 1, 1 = keep largest and drain descending; 0 = keep smallest and drain ascending
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample present
- in_ready  out  1  block accepts the sample this cycle
- in_data  in  DATA_W  signed sample
- in_last  in  1  marks the final sample of the frame
- out_valid  out  1  ranked result present
- out_ready  in  1  downstream accepts the result
- out_data  out  DATA_W  ranked sample, best first
- out_idx  out  IDX_W  arrival index of the sample within its frame, first = 0
- out_last  out  1  final result beat of the frame
- out_ovf  out  1  frame exceeded 2^IDX_W samples; valid on every drain beat

## Operation
- FSM has two states. FILL: in_ready=1, out_valid=0. DRAIN: in_ready=0, out_valid=1.
- Accept: in_valid & in_ready. Each accepted sample is compared signed against all K slots in parallel.
  - Slot i takes the new sample if it ranks strictly better than slot i's content, or if slot i is empty, and slot i-1 does not also lose.
  - Slots below the insertion point shift down by one; the slot-K-1 content is dropped.
- Empty slots (per-slot valid bit clear) always lose.
- Ties: the earlier arrival ranks higher, so a new sample inserts after equal ones. The drain order is stable.
- Index counter:
  - Increments per accepted sample and clears at frame start.
  - At 2^IDX_W-1 it saturates and sets sticky ovf; ovf clears at frame start.
- Accept with in_last: insert that sample, latch count = min(frame length, K), go to DRAIN.
- DRAIN:
  - out_data/out_idx = slot 0.
  - On out_ready the bank shifts up one, clearing the vacated slot, and the emitted counter increments.
  - out_last = 1 on beat count-1; handshake on that beat returns to FILL with the bank empty.
- A frame of L < K samples emits exactly L beats. A one-sample frame emits one beat with out_last=1.
- rst at any time: bank valid bits clear, counters 0, ovf 0, state FILL. The partial frame or partial drain is discarded without emitting out_last.

## Timing
- Reset values: in_ready=0 while rst=1 and 1 from the first cycle after; out_valid=0, out_data=0, out_idx=0, out_last=0, out_ovf=0.
- Insertion is single-cycle, one sample per clock, with no bubbles in FILL.
- in_last accepted at edge t → out_valid=1 from edge t+1.
- Drain runs at one beat per cycle while out_ready=1. With out_ready=0, out_data/out_idx/out_last hold stable and out_valid stays 1.
- A new frame can be accepted on the cycle after the out_last handshake.
- Frame of L samples costs L + min(L,K) cycles at full throughput.
- All outputs are registered. The comparison path is one compare plus a 3:1 mux per slot, with no chained compares.

## Structure
- Shared package sorter_pkg holds:
  - FSM state encoding (FILL/DRAIN)
  - FRAC_BITS=6
  - the default DATA_W
  - a better(a, b, sortdir) signed compare function reused by the parallel sorter benches
- Sub-module topk_slot: one bank entry holding data, idx and valid. Inputs are the new sample, the upper neighbour (for insert shift), the lower neighbour (for drain shift) and the mode. It generates its own "new ranks better" flag. It is instantiated K times in a generate loop.
- The top level holds the FSM, index/emit counters and ovf.

## Test plan
Default bench parameters: K_LOG2=2 (K=4), SORTDIR=1.
- Frame 5, -3, 12, 7, 0, 12 (last) with out_ready=1 → beats (12,idx2), (12,idx5), (7,idx3), (5,idx0); out_last on beat 4; out_valid one cycle after in_last.
- Frame of 2 samples 100, -100 (last) → exactly 2 beats (100,0), (-100,1); out_last on beat 2.
- SORTDIR=0, frame 1024 samples from a file or descending 1023..0 → beats 0, 1, 2, 3 with idx 1023, 1022, 1021, 1020.
- Drain with out_ready toggling 1,0,0,1,… → outputs held while stalled; in_ready=0 throughout the drain; a new frame is accepted on the cycle after the out_last handshake.
- IDX_W=4, frame of 20 samples → out_ovf=1 on all drain beats; the next frame of 3 samples → out_ovf=0.
- rst pulsed after 2 drain beats of a 4-beat frame → out_valid=0 next cycle, in_ready=1; next frame 9 (last) → a single beat (9,0) with out_last=1.
